// File: rtl/execute_stage_pkg.sv
// Shared pipeline definitions for the execute stage.
// Contents:
//   - ALU operation encodings (alu_op_e)
//   - Forward-select codes (fwd_sel_e). Code 2'b11 is reserved and behaves as FWD_REG.
//   - Flag bit positions inside the {N,Z,C,V} flag vector
//   - EX/MEM register layout (exmem_t) and its bubble value
//   - fwd_select(): the operand forwarding mux
package execute_stage_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Bit positions within flagsM = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [3:0]  flags;
    } exmem_t;

    // A bubble carries no controls and no data.
    localparam exmem_t EXMEM_BUBBLE = '0;

    // Operand forwarding: the reserved code falls back to register-file data.
    function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                               input logic [31:0] rf_data,
                                               input logic [31:0] wb_data,
                                               input logic [31:0] mem_data);
        logic [31:0] r;
        case (sel)
            FWD_WB:  r = wb_data;
            FWD_MEM: r = mem_data;
            default: r = rf_data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bus: ID/EX-side inputs, forwarding data, branch outputs and
// EX/MEM-side registered outputs.
//   master : the surrounding pipeline (drives E-stage signals, observes M-stage)
//   slave  : the execute stage itself
interface execute_stage_if;
    // E-stage inputs
    logic        valid_E;
    logic        stall_M;
    logic        flush_M;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic        ALUSrcE;
    logic        BranchE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ResultW;
    // Combinational branch outputs
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    // Registered M-stage outputs
    logic        valid_M;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [3:0]  flagsM;

    modport master (
        output valid_E, stall_M, flush_M, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               ALUSrcE, BranchE, RegWriteE, MemWriteE, ResultSrcE, ALUControlE,
               RD_E, ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, valid_M, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, ALU_ResultM, WriteDataM, PCPlus4M, flagsM
    );

    modport slave (
        input  valid_E, stall_M, flush_M, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               ALUSrcE, BranchE, RegWriteE, MemWriteE, ResultSrcE, ALUControlE,
               RD_E, ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, valid_M, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, ALU_ResultM, WriteDataM, PCPlus4M, flagsM
    );
endinterface

// File: rtl/execute_stage_alu.sv
// 32-bit ALU: add, sub, and, or, slt. Unknown codes produce 0.
// Ports:
//   A, B        operands
//   ALUControl  operation (alu_op_e encoding)
//   Result      result
//   V, C        signed overflow / carry-out, only meaningful for add and sub
//   Z, N        result zero / result sign
module execute_stage_alu
    import execute_stage_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        V,
    output logic        C,
    output logic        Z,
    output logic        N
);
    // Bit 0 selects subtraction for both sub (001) and slt (101).
    logic        do_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        is_arith;
    logic        sum_ovf;

    assign do_sub   = ALUControl[0];
    assign b_eff    = do_sub ? ~B : B;
    assign sum      = {1'b0, A} + {1'b0, b_eff} + {32'd0, do_sub};
    assign is_arith = (ALUControl == ALU_ADD) || (ALUControl == ALU_SUB);
    // Overflow: operands of equal sign give a sum of the other sign.
    assign sum_ovf  = (A[31] == b_eff[31]) && (sum[31] != A[31]);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: Result = sum[31:0];
            ALU_AND:          Result = A & B;
            ALU_OR:           Result = A | B;
            ALU_SLT:          Result = {31'd0, sum[31]};
            default:          Result = '0;
        endcase
    end

    assign C = is_arith & sum[32];
    assign V = is_arith & sum_ovf;
    assign Z = (Result == 32'd0);
    assign N = Result[31];
endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage with EX/MEM register and overflow event counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ex         execute_stage_if.slave: E-stage inputs, branch outputs
//              (PCSrcE/PCTargetE, combinational) and registered M-stage outputs
//   ovf_count  saturating count of captured instructions with signed overflow
// Parameters:
//   CNT_W      width of ovf_count
//   XLEN       datapath width, only 32 supported
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst,
    execute_stage_if.slave     ex,
    output logic [CNT_W-1:0]   ovf_count
);
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_v, alu_c, alu_z, alu_n;

    exmem_t          m_q, m_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    // Forward-from-MEM uses the register as it stands, so a stalled
    // instruction keeps feeding the held result.
    assign src_a = fwd_select(ex.ForwardA_E, ex.RD1_E, ex.ResultW, m_q.alu_result);
    assign fwd_b = fwd_select(ex.ForwardB_E, ex.RD2_E, ex.ResultW, m_q.alu_result);
    assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;

    execute_stage_alu u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ex.ALUControlE),
        .Result     (alu_result),
        .V          (alu_v),
        .C          (alu_c),
        .Z          (alu_z),
        .N          (alu_n)
    );

    // Branch resolution (beq only), unregistered.
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
    assign ex.PCSrcE    = ex.valid_E & ex.BranchE & alu_z;

    always_comb begin
        m_d   = m_q;
        ovf_d = ovf_q;
        if (ex.flush_M) begin
            m_d = EXMEM_BUBBLE;
        end else if (!ex.stall_M) begin
            if (ex.valid_E) begin
                m_d.valid             = 1'b1;
                m_d.reg_write         = ex.RegWriteE;
                m_d.mem_write         = ex.MemWriteE;
                m_d.result_src        = ex.ResultSrcE;
                m_d.rd                = ex.RD_E;
                m_d.alu_result        = alu_result;
                m_d.write_data        = fwd_b;
                m_d.pc_plus4          = ex.PCPlus4E;
                m_d.flags             = '0;
                m_d.flags[FLAG_N]     = alu_n;
                m_d.flags[FLAG_Z]     = alu_z;
                m_d.flags[FLAG_C]     = alu_c;
                m_d.flags[FLAG_V]     = alu_v;
                if (alu_v && (ovf_q != {CNT_W{1'b1}})) begin
                    ovf_d = ovf_q + CNT_W'(1);
                end
            end else begin
                // An invalid slot must not leak any write downstream.
                m_d = EXMEM_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= EXMEM_BUBBLE;
            ovf_q <= '0;
        end else begin
            m_q   <= m_d;
            ovf_q <= ovf_d;
        end
    end

    assign ex.valid_M     = m_q.valid;
    assign ex.RegWriteM   = m_q.reg_write;
    assign ex.MemWriteM   = m_q.mem_write;
    assign ex.ResultSrcM  = m_q.result_src;
    assign ex.RD_M        = m_q.rd;
    assign ex.ALU_ResultM = m_q.alu_result;
    assign ex.WriteDataM  = m_q.write_data;
    assign ex.PCPlus4M    = m_q.pc_plus4;
    assign ex.flagsM      = m_q.flags;
    assign ovf_count      = ovf_q;
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter CNT_W, default 16: width of the overflow event counter.
REQ-003 SHALL have parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 valid_E  in  1  the ID/EX slot holds a real instruction.
REQ-007 stall_M  in  1  hold the EX/MEM register (downstream back-pressure).
REQ-008 flush_M  in  1  load a bubble into the EX/MEM register.
REQ-009 RD1_E, RD2_E  in  32  register-file read data.
REQ-010 Imm_Ext_E, PCE, PCPlus4E  in  32  immediate, PC, and PC+4.
REQ-011 ALUSrcE, BranchE, RegWriteE, MemWriteE, ResultSrcE  in  1 each  decoded controls.
REQ-012 ALUControlE  in  3  ALU operation.
REQ-013 RD_E  in  5  destination register.
REQ-014 ForwardA_E, ForwardB_E  in  2  operand source select.
REQ-015 ResultW  in  32  writeback-stage result, used for forwarding.
REQ-016 PCSrcE  out  1  branch taken, combinational.
REQ-017 PCTargetE  out  32  branch target, combinational.
REQ-018 valid_M, RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls.
REQ-019 RD_M  out  5  registered destination register.
REQ-020 ALU_ResultM, WriteDataM, PCPlus4M  out  32  registered data.
REQ-021 flagsM  out  4  registered {N,Z,C,V}.
REQ-022 ovf_count  out  CNT_W  saturating count of signed-overflow events.

Function
REQ-023 Forward select SHALL be:
- 00: register-file data.
- 01: ResultW.
- 10: the current ALU_ResultM register.
- 11: reserved, treated as 00.
REQ-024 SrcA SHALL be forwarded A; SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else forwarded B; WriteData SHALL be forwarded B.
REQ-025 ALU encodings SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed via sum sign bit); any other code SHALL give result 0.
REQ-026 Flags: Z = result==0; N = result[31]; C = adder carry-out, add/sub only; V = signed overflow, add/sub only; C and V SHALL be 0 for logic ops and slt.
REQ-027 PCTargetE SHALL be PCE+Imm_Ext_E, modulo 2^32.
REQ-028 PCSrcE SHALL be valid_E & BranchE & Z, in the same cycle with no register; branch is beq only.
REQ-029 Each edge, the EX/MEM register SHALL be updated in this priority order:
- rst: clear everything.
- flush_M: bubble.
- stall_M: hold all values.
- otherwise: capture.
REQ-030 A bubble SHALL set valid_M=0, RegWriteM=0, MemWriteM=0 and ResultSrcM=0; data fields SHALL be cleared to 0.
REQ-031 Capture with valid_E=0 SHALL load a bubble, so no architectural write leaks.
REQ-032 flush_M and stall_M asserted together SHALL produce a flush.
REQ-033 Latency SHALL be one cycle from the E inputs to the M outputs.
REQ-034 When stall_M=1 and a forward select is 10, the held ALU_ResultM SHALL be used.
REQ-035 ovf_count SHALL increment by 1 on each edge where an instruction is captured (not stalled, not flushed, valid_E=1) and V=1.
REQ-036 ovf_count SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-037 On rst, all registered outputs SHALL be 0: valid_M, controls, RD_M, ALU_ResultM, WriteDataM, PCPlus4M, flagsM, ovf_count.
REQ-038 rst SHALL override stall_M and flush_M; a rst mid-stall SHALL discard the held instruction.
REQ-039 Combinational outputs SHALL follow their inputs during reset, but PCSrcE SHALL be 0 whenever valid_E=0.

Structure
REQ-040 The ALUControl encodings, the forward-select codes (FWD_REG, FWD_WB, FWD_MEM) and the flag bit order SHALL live in a shared pipeline package.
REQ-041 The block SHALL instantiate the team's existing ALU module (ports A, B, Result, ALUControl, V, C, Z, N) as its sole sub-module.
REQ-042 Forwarding muxes, the branch adder, the EX/MEM register and the counter SHALL be local logic.

Verification
REQ-043 Add with overflow: A=0x7FFFFFFF, B=1, ALUControl=000, valid_E=1 -> next cycle ALU_ResultM=0x80000000, flagsM=1001, ovf_count=1.
REQ-044 Taken branch: ALUControl=001, RD1=RD2=5, BranchE=1, PCE=0x100, Imm=0x20 -> same cycle PCSrcE=1, PCTargetE=0x120; with valid_E=0 -> PCSrcE=0.
REQ-045 Forwarding: ForwardA=10 with ALU_ResultM=7, ForwardB=01 with ResultW=3, add -> ALU_ResultM=10; ForwardB=11 -> RD2 is used.
REQ-046 Stall and flush:
- stall_M for 3 cycles -> outputs held.
- stall_M=flush_M=1 -> valid_M=0, RegWriteM=0.
- rst during stall -> all outputs 0.
REQ-047 Counter saturation: CNT_W=2, five overflowing adds -> ovf_count = 0,1,2,3,3,3; a flushed or stalled overflow SHALL not count.
REQ-048 slt: A=0xFFFFFFFF, B=1, ALUControl=101 -> ALU_ResultM=1, C=V=0.
